// File: rtl/write_back_queue_pkg.sv
// Shared types for the in-order write-back queue: source select, queue entry and load funct3 codes.
package write_back_pkg;

  localparam int WB_XLEN       = 32;
  localparam int WB_REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    WB_SEL_ALU = 2'd0,
    WB_SEL_MEM = 2'd1,
    WB_SEL_PC  = 2'd2
  } write_back_select_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Entry storage is sized by the package widths; the top's XLEN/REG_ADDR_W must match them.
  typedef struct packed {
    logic                     we;
    logic [WB_REG_ADDR_W-1:0] rd;
    write_back_select_t       sel;
    logic [2:0]               funct3;
    logic [WB_XLEN-1:0]       data;
    logic                     data_ok;
  } wb_entry_t;

endpackage

// File: rtl/write_back_queue_if.sv
// Record/response inputs and register-file write outputs of the write-back queue.
interface write_back_queue_if
  import write_back_pkg::*;
#(
  parameter int XLEN       = WB_XLEN,
  parameter int DEPTH      = 4,
  parameter int REG_ADDR_W = WB_REG_ADDR_W
) ();

  logic                         in_valid;
  logic                         in_ready;
  logic                         in_write_enable;
  logic [REG_ADDR_W-1:0]        in_rd;
  write_back_select_t           in_sel;
  logic [2:0]                   in_funct3;
  logic [XLEN-1:0]              in_alu_result;
  logic [XLEN-1:0]              in_pc_plus4;
  logic                         mem_rsp_valid;
  logic [XLEN-1:0]              mem_rsp_data;
  logic                         rf_we;
  logic [REG_ADDR_W-1:0]        rf_rd;
  logic [XLEN-1:0]              rf_wdata;
  logic [$clog2(DEPTH+1)-1:0]   occupancy;
  logic                         rsp_orphan;

  modport master (
    output in_valid, in_write_enable, in_rd, in_sel, in_funct3, in_alu_result, in_pc_plus4,
    output mem_rsp_valid, mem_rsp_data,
    input  in_ready, rf_we, rf_rd, rf_wdata, occupancy, rsp_orphan
  );

  modport slave (
    input  in_valid, in_write_enable, in_rd, in_sel, in_funct3, in_alu_result, in_pc_plus4,
    input  mem_rsp_valid, mem_rsp_data,
    output in_ready, rf_we, rf_rd, rf_wdata, occupancy, rsp_orphan
  );

endinterface

// File: rtl/write_back_queue_load_extend.sv
// Combinational load-data extender: sign/zero-extends byte and halfword loads by funct3.
module load_extend
  import write_back_pkg::*;
#(
  parameter int XLEN = WB_XLEN
) (
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_data,
  output logic [XLEN-1:0] o_data
);

  function automatic logic [XLEN-1:0] extend_load(input logic [2:0] f3, input logic [XLEN-1:0] d);
    logic signed [7:0]  s_b;
    logic signed [15:0] s_h;
    logic [XLEN-1:0]    r;
    s_b = d[7:0];
    s_h = d[15:0];
    case (f3)
      F3_LB:   r = XLEN'(s_b);
      F3_LH:   r = XLEN'(s_h);
      F3_LBU:  r = XLEN'(d[7:0]);
      F3_LHU:  r = XLEN'(d[15:0]);
      F3_LW:   r = d;
      default: r = d;
    endcase
    return r;
  endfunction

  assign o_data = extend_load(i_funct3, i_data);

endmodule

// File: rtl/write_back_queue.sv
// In-order write-back queue: buffers records, fills loads from in-order responses, retires to a registered RF port.
// Optional WB_BYPASS_EN: non-load records offered to an empty queue go straight to the output register.
module write_back_queue
  import write_back_pkg::*;
#(
  parameter int XLEN       = WB_XLEN,
  parameter int DEPTH      = 4,
  parameter int REG_ADDR_W = WB_REG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  write_back_queue_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t             r_q [DEPTH];
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;
  logic                  r_rf_we_p1;
  logic [REG_ADDR_W-1:0] r_rf_rd_p1;
  logic [XLEN-1:0]       r_rf_wdata_p1;
  logic                  r_orphan_p1;

  logic                  w_ready;
  logic                  w_enq;
  logic                  w_retire;
  logic                  w_bypass;
  logic                  w_fill_hit;
  logic [PW-1:0]         w_fill_idx;
  logic [XLEN-1:0]       w_ext;
  logic [XLEN-1:0]       w_in_value;

  assign w_ready    = (r_count < CW'(DEPTH));
  assign w_retire   = (r_count != '0) && r_q[r_head].data_ok;
  assign w_in_value = (bus.in_sel == WB_SEL_PC) ? bus.in_pc_plus4 : bus.in_alu_result;

`ifdef WB_BYPASS_EN
  assign w_bypass = (r_count == '0) && bus.in_valid && (bus.in_sel != WB_SEL_MEM);
`else
  assign w_bypass = 1'b0;
`endif

  assign w_enq = bus.in_valid && w_ready && !w_bypass;

  // Stage p0: oldest stored load still waiting for data; same-cycle enqueues are not yet counted.
  always_comb begin
    w_fill_hit = 1'b0;
    w_fill_idx = r_head;
    for (int k = 0; k < DEPTH; k++) begin
      if (!w_fill_hit && (CW'(k) < r_count) &&
          (r_q[r_head + PW'(k)].sel == WB_SEL_MEM) && !r_q[r_head + PW'(k)].data_ok) begin
        w_fill_hit = 1'b1;
        w_fill_idx = r_head + PW'(k);
      end
    end
  end

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .i_funct3 (r_q[w_fill_idx].funct3),
    .i_data   (bus.mem_rsp_data),
    .o_data   (w_ext)
  );

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_q[r_tail] <= '{we:      bus.in_write_enable,
                       rd:      bus.in_rd,
                       sel:     bus.in_sel,
                       funct3:  bus.in_funct3,
                       data:    w_in_value,
                       data_ok: (bus.in_sel != WB_SEL_MEM)};
    end
    if (bus.mem_rsp_valid && w_fill_hit) begin
      r_q[w_fill_idx].data    <= w_ext;
      r_q[w_fill_idx].data_ok <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq)    r_tail <= r_tail + PW'(1);
      if (w_retire) r_head <= r_head + PW'(1);
      case ({w_enq, w_retire})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Stage p1: registered register-file write port; address and data hold when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rf_we_p1    <= 1'b0;
      r_rf_rd_p1    <= '0;
      r_rf_wdata_p1 <= '0;
      r_orphan_p1   <= 1'b0;
    end else begin
      r_orphan_p1 <= bus.mem_rsp_valid && !w_fill_hit;
      if (w_retire) begin
        r_rf_we_p1    <= r_q[r_head].we && (r_q[r_head].rd != '0);
        r_rf_rd_p1    <= r_q[r_head].rd;
        r_rf_wdata_p1 <= r_q[r_head].data;
      end else if (w_bypass) begin
        r_rf_we_p1    <= bus.in_write_enable && (bus.in_rd != '0);
        r_rf_rd_p1    <= bus.in_rd;
        r_rf_wdata_p1 <= w_in_value;
      end else begin
        r_rf_we_p1 <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = w_ready;
  assign bus.rf_we      = r_rf_we_p1;
  assign bus.rf_rd      = r_rf_rd_p1;
  assign bus.rf_wdata   = r_rf_wdata_p1;
  assign bus.occupancy  = r_count;
  assign bus.rsp_orphan = r_orphan_p1;

endmodule

// File: tb/tb_write_back_queue.sv
// Bench for write_back_queue: directed vector table, hand sequences and random traffic against a queue model.
module tb_write_back_queue;
  import write_back_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int RW    = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  write_back_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH), .REG_ADDR_W(RW)) bus ();

  write_back_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .REG_ADDR_W(RW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic               we;
    logic [4:0]         rd;
    write_back_select_t sel;
    logic [2:0]         f3;
    logic [31:0]        data;
    bit                 ok;
  } mrec_t;

  mrec_t       m_q[$];
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;
  logic        m_orph;

  typedef struct {
    logic iv; logic we; logic [4:0] rd; write_back_select_t sel; logic [2:0] f3;
    logic [31:0] alu; logic [31:0] pc; logic rv; logic [31:0] rdat;
    logic e_we; logic [4:0] e_rd; logic [31:0] e_wd; logic [2:0] e_occ; logic e_orph;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t row(input logic iv, input logic we, input logic [4:0] rd,
                               input write_back_select_t sel, input logic [2:0] f3,
                               input logic [31:0] alu, input logic [31:0] pc,
                               input logic rv, input logic [31:0] rdat,
                               input logic e_we, input logic [4:0] e_rd, input logic [31:0] e_wd,
                               input logic [2:0] e_occ, input logic e_orph);
    vec_t v;
    v.iv = iv; v.we = we; v.rd = rd; v.sel = sel; v.f3 = f3; v.alu = alu; v.pc = pc;
    v.rv = rv; v.rdat = rdat; v.e_we = e_we; v.e_rd = e_rd; v.e_wd = e_wd;
    v.e_occ = e_occ; v.e_orph = e_orph;
    return v;
  endfunction

  function automatic logic [31:0] ref_ext(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  return d[7]  ? (32'hFFFF_FF00 | {24'h0, d[7:0]}) : {24'h0, d[7:0]};
      3'b001:  return d[15] ? (32'hFFFF_0000 | {16'h0, d[15:0]}) : {16'h0, d[15:0]};
      3'b100:  return {24'h0, d[7:0]};
      3'b101:  return {16'h0, d[15:0]};
      default: return d;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_rec(input logic v, input logic we, input logic [4:0] rd,
                           input write_back_select_t sel, input logic [2:0] f3,
                           input logic [31:0] alu, input logic [31:0] pc);
    bus.in_valid = v; bus.in_write_enable = we; bus.in_rd = rd; bus.in_sel = sel;
    bus.in_funct3 = f3; bus.in_alu_result = alu; bus.in_pc_plus4 = pc;
  endtask

  task automatic drive_rsp(input logic v, input logic [31:0] d);
    bus.mem_rsp_valid = v; bus.mem_rsp_data = d;
  endtask

  task automatic idle();
    drive_rec(1'b0, 1'b0, 5'd0, WB_SEL_ALU, 3'd0, 32'd0, 32'd0);
    drive_rsp(1'b0, 32'd0);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_we = 1'b0; m_rd = 5'd0; m_wd = 32'd0; m_orph = 1'b0;
  endtask

  // One clock: predict from the driven inputs, advance, compare every output.
  task automatic tick();
    bit    retire, found, acc, byp;
    int    fi;
    mrec_t e;
    logic [31:0] in_val;
    chk("in_ready", 32'(bus.in_ready), 32'(m_q.size() < DEPTH));
    retire = (m_q.size() > 0) && m_q[0].ok;
    found  = 1'b0;
    fi     = 0;
    foreach (m_q[i]) if (!found && m_q[i].sel == WB_SEL_MEM && !m_q[i].ok) begin found = 1'b1; fi = i; end
    acc = bus.in_valid && (m_q.size() < DEPTH);
    byp = 1'b0;
`ifdef WB_BYPASS_EN
    byp = acc && (m_q.size() == 0) && (bus.in_sel != WB_SEL_MEM);
`endif
    in_val = (bus.in_sel == WB_SEL_PC) ? bus.in_pc_plus4 : bus.in_alu_result;
    if (bus.mem_rsp_valid && found) begin
      m_q[fi].data = ref_ext(m_q[fi].f3, bus.mem_rsp_data);
      m_q[fi].ok   = 1'b1;
    end
    m_orph = bus.mem_rsp_valid && !found;
    if (retire) begin
      e = m_q.pop_front();
      m_we = e.we && (e.rd != 5'd0); m_rd = e.rd; m_wd = e.data;
    end else if (byp) begin
      m_we = bus.in_write_enable && (bus.in_rd != 5'd0); m_rd = bus.in_rd; m_wd = in_val;
    end else begin
      m_we = 1'b0;
    end
    if (acc && !byp) begin
      e.we = bus.in_write_enable; e.rd = bus.in_rd; e.sel = bus.in_sel; e.f3 = bus.in_funct3;
      e.data = in_val; e.ok = (bus.in_sel != WB_SEL_MEM);
      m_q.push_back(e);
    end
    @(posedge clk); #1;
    chk("rf_we",      32'(bus.rf_we),      32'(m_we));
    chk("rf_rd",      32'(bus.rf_rd),      32'(m_rd));
    chk("rf_wdata",   bus.rf_wdata,        m_wd);
    chk("occupancy",  32'(bus.occupancy),  32'(m_q.size()));
    chk("rsp_orphan", 32'(bus.rsp_orphan), 32'(m_orph));
  endtask

  initial begin
    idle();
    model_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset rf_we",      32'(bus.rf_we),      32'd0);
    chk("reset rf_rd",      32'(bus.rf_rd),      32'd0);
    chk("reset rf_wdata",   bus.rf_wdata,        32'd0);
    chk("reset occupancy",  32'(bus.occupancy),  32'd0);
    chk("reset rsp_orphan", 32'(bus.rsp_orphan), 32'd0);
    chk("reset in_ready",   32'(bus.in_ready),   32'd1);
    reset = 1'b0;

`ifndef WB_BYPASS_EN
    // iv we rd sel f3 alu pc | rv rdat | e_we e_rd e_wd e_occ e_orph
    vt.push_back(row(1'b1,1'b1,5'd5,WB_SEL_ALU,3'b000,32'h1234,32'h0, 1'b0,32'h0,   1'b0,5'd0,32'h0,3'd1,1'b0));
    vt.push_back(row(1'b0,1'b0,5'd0,WB_SEL_ALU,3'b000,32'h0,32'h0,    1'b0,32'h0,   1'b1,5'd5,32'h1234,3'd0,1'b0));
    vt.push_back(row(1'b0,1'b0,5'd0,WB_SEL_ALU,3'b000,32'h0,32'h0,    1'b0,32'h0,   1'b0,5'd5,32'h1234,3'd0,1'b0));
    vt.push_back(row(1'b1,1'b1,5'd3,WB_SEL_MEM,3'b000,32'h0,32'h0,    1'b0,32'h0,   1'b0,5'd5,32'h1234,3'd1,1'b0));
    vt.push_back(row(1'b0,1'b0,5'd0,WB_SEL_ALU,3'b000,32'h0,32'h0,    1'b0,32'h0,   1'b0,5'd5,32'h1234,3'd1,1'b0));
    vt.push_back(row(1'b0,1'b0,5'd0,WB_SEL_ALU,3'b000,32'h0,32'h0,    1'b1,32'hF0,  1'b0,5'd5,32'h1234,3'd1,1'b0));
    vt.push_back(row(1'b0,1'b0,5'd0,WB_SEL_ALU,3'b000,32'h0,32'h0,    1'b0,32'h0,   1'b1,5'd3,32'hFFFF_FFF0,3'd0,1'b0));
    vt.push_back(row(1'b1,1'b1,5'd3,WB_SEL_MEM,3'b100,32'h0,32'h0,    1'b0,32'h0,   1'b0,5'd3,32'hFFFF_FFF0,3'd1,1'b0));
    vt.push_back(row(1'b0,1'b0,5'd0,WB_SEL_ALU,3'b000,32'h0,32'h0,    1'b0,32'h0,   1'b0,5'd3,32'hFFFF_FFF0,3'd1,1'b0));
    vt.push_back(row(1'b0,1'b0,5'd0,WB_SEL_ALU,3'b000,32'h0,32'h0,    1'b1,32'hF0,  1'b0,5'd3,32'hFFFF_FFF0,3'd1,1'b0));
    vt.push_back(row(1'b0,1'b0,5'd0,WB_SEL_ALU,3'b000,32'h0,32'h0,    1'b0,32'h0,   1'b1,5'd3,32'hF0,3'd0,1'b0));
    vt.push_back(row(1'b1,1'b1,5'd7,WB_SEL_MEM,3'b001,32'h0,32'h0,    1'b0,32'h0,   1'b0,5'd3,32'hF0,3'd1,1'b0));
    vt.push_back(row(1'b0,1'b0,5'd0,WB_SEL_ALU,3'b000,32'h0,32'h0,    1'b0,32'h0,   1'b0,5'd3,32'hF0,3'd1,1'b0));
    vt.push_back(row(1'b0,1'b0,5'd0,WB_SEL_ALU,3'b000,32'h0,32'h0,    1'b1,32'h8001,1'b0,5'd3,32'hF0,3'd1,1'b0));
    vt.push_back(row(1'b0,1'b0,5'd0,WB_SEL_ALU,3'b000,32'h0,32'h0,    1'b0,32'h0,   1'b1,5'd7,32'hFFFF_8001,3'd0,1'b0));
    vt.push_back(row(1'b0,1'b0,5'd0,WB_SEL_ALU,3'b000,32'h0,32'h0,    1'b1,32'h55,  1'b0,5'd7,32'hFFFF_8001,3'd0,1'b1));
    vt.push_back(row(1'b1,1'b1,5'd0,WB_SEL_PC, 3'b000,32'h0,32'h100,  1'b0,32'h0,   1'b0,5'd7,32'hFFFF_8001,3'd1,1'b0));
    vt.push_back(row(1'b0,1'b0,5'd0,WB_SEL_ALU,3'b000,32'h0,32'h0,    1'b0,32'h0,   1'b0,5'd0,32'h100,3'd0,1'b0));
    vt.push_back(row(1'b1,1'b1,5'd1,WB_SEL_MEM,3'b010,32'h0,32'h0,    1'b0,32'h0,   1'b0,5'd0,32'h100,3'd1,1'b0));
    vt.push_back(row(1'b1,1'b1,5'd2,WB_SEL_ALU,3'b000,32'hA,32'h0,    1'b0,32'h0,   1'b0,5'd0,32'h100,3'd2,1'b0));
    vt.push_back(row(1'b1,1'b1,5'd4,WB_SEL_MEM,3'b010,32'h0,32'h0,    1'b0,32'h0,   1'b0,5'd0,32'h100,3'd3,1'b0));
    vt.push_back(row(1'b0,1'b0,5'd0,WB_SEL_ALU,3'b000,32'h0,32'h0,    1'b1,32'h11,  1'b0,5'd0,32'h100,3'd3,1'b0));
    vt.push_back(row(1'b0,1'b0,5'd0,WB_SEL_ALU,3'b000,32'h0,32'h0,    1'b1,32'h44,  1'b1,5'd1,32'h11,3'd2,1'b0));
    vt.push_back(row(1'b0,1'b0,5'd0,WB_SEL_ALU,3'b000,32'h0,32'h0,    1'b0,32'h0,   1'b1,5'd2,32'hA,3'd1,1'b0));
    vt.push_back(row(1'b0,1'b0,5'd0,WB_SEL_ALU,3'b000,32'h0,32'h0,    1'b0,32'h0,   1'b1,5'd4,32'h44,3'd0,1'b0));
    vt.push_back(row(1'b0,1'b0,5'd0,WB_SEL_ALU,3'b000,32'h0,32'h0,    1'b0,32'h0,   1'b0,5'd4,32'h44,3'd0,1'b0));
    foreach (vt[i]) begin
      drive_rec(vt[i].iv, vt[i].we, vt[i].rd, vt[i].sel, vt[i].f3, vt[i].alu, vt[i].pc);
      drive_rsp(vt[i].rv, vt[i].rdat);
      tick();
      chk($sformatf("vec%0d rf_we", i),      32'(bus.rf_we),      32'(vt[i].e_we));
      chk($sformatf("vec%0d rf_rd", i),      32'(bus.rf_rd),      32'(vt[i].e_rd));
      chk($sformatf("vec%0d rf_wdata", i),   bus.rf_wdata,        vt[i].e_wd);
      chk($sformatf("vec%0d occupancy", i),  32'(bus.occupancy),  32'(vt[i].e_occ));
      chk($sformatf("vec%0d rsp_orphan", i), 32'(bus.rsp_orphan), 32'(vt[i].e_orph));
    end
    idle();
`endif

    // Full queue: four loads, a fifth offer is refused until the head retires.
    for (int i = 0; i < DEPTH; i++) begin
      drive_rec(1'b1, 1'b1, 5'(8 + i), WB_SEL_MEM, 3'b010, 32'h0, 32'h0);
      tick();
    end
    drive_rec(1'b1, 1'b1, 5'd12, WB_SEL_MEM, 3'b010, 32'h0, 32'h0);
    chk("full in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("full occupancy", 32'(bus.occupancy), 32'd4);
    idle();
    drive_rsp(1'b1, 32'h8);
    tick();
    chk("full fill in_ready", 32'(bus.in_ready), 32'd0);
    idle();
    tick();
    chk("full retire in_ready", 32'(bus.in_ready), 32'd1);
    chk("full retire rf_rd",    32'(bus.rf_rd),    32'd8);
    chk("full retire rf_we",    32'(bus.rf_we),    32'd1);
    for (int i = 0; i < 3; i++) begin
      drive_rsp(1'b1, 32'(16 + i));
      tick();
    end
    idle();
    repeat (2) tick();

    // Reset with two loads pending clears outputs at once; a later response is orphaned.
    drive_rec(1'b1, 1'b1, 5'd13, WB_SEL_MEM, 3'b010, 32'h0, 32'h0);
    tick();
    drive_rec(1'b1, 1'b1, 5'd14, WB_SEL_MEM, 3'b000, 32'h0, 32'h0);
    tick();
    idle();
    reset = 1'b1;
    #1;
    chk("async rst rf_we",      32'(bus.rf_we),      32'd0);
    chk("async rst rf_rd",      32'(bus.rf_rd),      32'd0);
    chk("async rst rf_wdata",   bus.rf_wdata,        32'd0);
    chk("async rst occupancy",  32'(bus.occupancy),  32'd0);
    chk("async rst rsp_orphan", 32'(bus.rsp_orphan), 32'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    drive_rsp(1'b1, 32'h99);
    tick();
    chk("post rst orphan", 32'(bus.rsp_orphan), 32'd1);
    chk("post rst rf_we",  32'(bus.rf_we),      32'd0);
    idle();
    tick();
    chk("orphan one cycle", 32'(bus.rsp_orphan), 32'd0);

    // Random traffic against the queue model.
    for (int c = 0; c < 400; c++) begin
      drive_rec(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 1)), 5'($urandom),
                write_back_select_t'(2'($urandom_range(0, 2))), 3'($urandom_range(0, 7)),
                $urandom, $urandom);
      drive_rsp(1'($urandom_range(0, 99) < 35), $urandom);
      tick();
    end
    idle();
    for (int c = 0; c < 12; c++) begin
      drive_rsp(1'b1, $urandom);
      tick();
    end
    idle();
    repeat (3) tick();
    chk("drained occupancy", 32'(bus.occupancy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
